// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier, one multiplier bit per clock.
// Optional MULTIPLIER_EARLY_DONE_EN: finish as soon as no partial products remain.
//
// state | meaning
// IDLE  | ready_i=1, waiting for operands
// BUSY  | shift-and-add, one multiplier bit per edge
// DONE  | valid_o=1, product held until ready_o
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_i,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           valid_o,
  input  logic           ready_o,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nx;
  logic [2*N-1:0] mcand, mcand_nx;
  logic [2*N-1:0] acc, acc_nx;
  logic [N-1:0]   mplier, mplier_nx;
  logic [CW-1:0]  cnt, cnt_nx;

  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    acc_nx    = acc;
    mplier_nx = mplier;
    cnt_nx    = cnt;
    case (state)
      IDLE: begin
        if (valid_i) begin
          mcand_nx  = {{N{1'b0}}, a};
          mplier_nx = b;
          acc_nx    = '0;
          cnt_nx    = CW'(N);
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        if (mplier[0]) acc_nx = acc + mcand;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = DONE;
`ifdef MULTIPLIER_EARLY_DONE_EN
        // a zero multiplicand adds nothing, so it can finish just as early
        if (mplier_nx == '0 || mcand == '0) state_nx = DONE;
`endif
      end
      DONE: begin
        if (ready_o) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      ready_i <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nx;
      mcand   <= mcand_nx;
      acc     <= acc_nx;
      mplier  <= mplier_nx;
      cnt     <= cnt_nx;
      ready_i <= (state_nx == IDLE);
      valid_o <= (state_nx == DONE);
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized self-checking bench for seq_multiplier (N=3).
module tb_seq_multiplier;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i;
  logic           ready_i;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           valid_o;
  logic           ready_o;
  logic [2*N-1:0] product;

  int tests = 0;
  int fails = 0;

  seq_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_i (ready_i),
    .a       (a),
    .b       (b),
    .valid_o (valid_o),
    .ready_o (ready_o),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int av, input int bv);
`ifdef MULTIPLIER_EARLY_DONE_EN
    if (av == 0 || bv == 0) return 1;
    for (int i = N - 1; i >= 0; i--)
      if (bv[i]) return i + 1;
    return 1;
`else
    return N;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready_i, then presents operands for exactly one edge.
  task automatic accept(input logic [N-1:0] av, input logic [N-1:0] bv);
    int k = 0;
    while (!ready_i && k < 20) begin
      step();
      k++;
    end
    valid_i = 1'b1;
    a = av;
    b = bv;
    step();
    valid_i = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!valid_o && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
    int lat;
    ready_o = 1'b1;
    accept(av, bv);
    wait_valid(0, lat);
    check({tag, "_lat"}, lat, exp_lat(av, bv));
    check({tag, "_prod"}, product, int'(av) * int'(bv));
    step();
    check({tag, "_vo_drop"}, valid_o, 1'b0);
    check({tag, "_ri_back"}, ready_i, 1'b1);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b0;
    valid_i = 1'b0;
    a = '0;
    b = '0;
    ready_o = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_i", ready_i, 1'b1);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();
    check("idle_ready_i", ready_i, 1'b1);
    check("idle_valid_o", valid_o, 1'b0);

    run("p7x7", 3'd7, 3'd7);
    run("p3x4", 3'd3, 3'd4);
    run("p0x5", 3'd0, 3'd5);

    // backpressure: result must hold while ready_o is low
    ready_o = 1'b0;
    accept(3'd5, 3'd6);
    wait_valid(0, lat);
    check("bp_lat", lat, exp_lat(5, 6));
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid_hold", valid_o, 1'b1);
      check("bp_prod_hold", product, 30);
    end
    ready_o = 1'b1;
    step();
    check("bp_vo_drop", valid_o, 1'b0);
    check("bp_ri_back", ready_i, 1'b1);

    // valid_i while BUSY must be ignored
    accept(3'd6, 3'd3);
    valid_i = 1'b1;
    a = 3'd2;
    b = 3'd2;
    step();
    valid_i = 1'b0;
    wait_valid(1, lat);
    check("ign_lat", lat, exp_lat(6, 3));
    check("ign_prod", product, 18);
    step();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_o) seen = 1'b1;
    end
    check("ign_no_second", seen, 1'b0);

    // asynchronous reset in the middle of an operation
    accept(3'd7, 3'd5);
    step();
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_ready_i", ready_i, 1'b1);
    check("mid_rst_valid_o", valid_o, 1'b0);
    check("mid_rst_product", product, 0);
    @(negedge clk);
    rst = 1'b1;
    run("post_rst_1x1", 3'd1, 3'd1);

    run("lat_b1", 3'd5, 3'd1);
    run("lat_b4", 3'd3, 3'd4);

    for (int i = 0; i < 1000; i++)
      run("rand", N'($urandom), N'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
